// File: rtl/vga_sync_receiver_if.sv
// ============================================================================
// vga_sync_receiver_if : sync/colour inputs and recovered video outputs
// Rev 1.0
// ============================================================================
`default_nettype none

interface vga_sync_receiver_if;
  logic       h_sync;
  logic       v_sync;
  logic [3:0] r_port;
  logic [3:0] g_port;
  logic [3:0] b_port;
  logic       DE;
  logic [9:0] x_pixel;
  logic [9:0] y_pixel;
  logic [3:0] r_out;
  logic [3:0] g_out;
  logic [3:0] b_out;
  logic       frame_start;
  logic       locked;
  logic [7:0] err_cnt;

  modport master (
    output h_sync, v_sync, r_port, g_port, b_port,
    input  DE, x_pixel, y_pixel, r_out, g_out, b_out, frame_start, locked, err_cnt
  );

  modport slave (
    input  h_sync, v_sync, r_port, g_port, b_port,
    output DE, x_pixel, y_pixel, r_out, g_out, b_out, frame_start, locked, err_cnt
  );
endinterface

`default_nettype wire

// File: rtl/vga_sync_receiver.sv
// ============================================================================
// vga_sync_receiver : recovers DE/x/y from VGA syncs, locks after good frames
// Optional error counter enabled by `define VGA_RX_ERR_CNT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module vga_sync_receiver #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                clk,
  input  logic                reset,
  vga_sync_receiver_if.slave  vga
);

  localparam logic [9:0] c_h_start = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] c_h_end   = 10'(H_SYNC + H_BACK + H_VISIBLE);
  localparam logic [9:0] c_h_last  = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] c_v_start = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] c_v_end   = 10'(V_SYNC + V_BACK + V_VISIBLE);
  localparam logic [9:0] c_v_last  = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] c_cnt_max = 10'h3ff;
  localparam logic [3:0] c_lock_n  = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  logic       hs_q, hs_d, hs_prev_q, vs_q, vs_d, vs_prev_q;
  logic [3:0] r_in_q, r_in_d, g_in_q, g_in_d, b_in_q, b_in_d;
  logic [9:0] h_cnt_q, h_cnt_d, line_q, line_d;
  logic       v_pend_q, v_pend_d;
  state_t     state_q, state_d;
  logic [3:0] good_cnt_q, good_cnt_d;
  logic       de_q, de_d, frame_start_q, frame_start_d, locked_q, locked_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [3:0] r_out_q, r_out_d, g_out_q, g_out_d, b_out_q, b_out_d;

  logic       h_edge, v_edge, line0_edge, bad_line, frame_len_bad, active;
  logic [9:0] h_pos, line_pos;

  // Position/line of the sample currently held in the input register.
  always_comb begin
    hs_d       = vga.h_sync;
    vs_d       = vga.v_sync;
    r_in_d     = vga.r_port;
    g_in_d     = vga.g_port;
    b_in_d     = vga.b_port;
    h_edge     = hs_prev_q & ~hs_q;
    v_edge     = vs_prev_q & ~vs_q;
    line0_edge = h_edge & (v_edge | v_pend_q);

    v_pend_d = v_pend_q;
    if (line0_edge)  v_pend_d = 1'b0;
    else if (v_edge) v_pend_d = 1'b1;

    if (h_edge)                    h_pos = 10'd0;
    else if (h_cnt_q == c_cnt_max) h_pos = c_cnt_max;
    else                           h_pos = h_cnt_q + 10'd1;

    if (line0_edge)                           line_pos = 10'd0;
    else if (h_edge && line_q != c_cnt_max)   line_pos = line_q + 10'd1;
    else                                      line_pos = line_q;

    h_cnt_d = h_pos;
    line_d  = line_pos;

    // Wrong line length at an edge, or the counter just reaching saturation.
    bad_line      = (h_edge && h_cnt_q != c_h_last) ||
                    (!h_edge && h_cnt_q == c_cnt_max - 10'd1);
    frame_len_bad = line_q != c_v_last;
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    case (state_q)
      ST_SEARCH: begin
        if (line0_edge) begin
          state_d    = ST_CHECK;
          good_cnt_d = 4'd0;
        end
      end
      ST_CHECK, ST_LOCKED: begin
        if (bad_line || (line0_edge && frame_len_bad)) begin
          state_d = ST_SEARCH;
        end else if (line0_edge && state_q == ST_CHECK) begin
          if (good_cnt_q + 4'd1 >= c_lock_n) state_d = ST_LOCKED;
          else                               good_cnt_d = good_cnt_q + 4'd1;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  always_comb begin
    active        = (h_pos >= c_h_start) && (h_pos < c_h_end) &&
                    (line_pos >= c_v_start) && (line_pos < c_v_end);
    locked_d      = (state_d == ST_LOCKED);
    de_d          = active && locked_d;
    x_d           = de_d ? h_pos - c_h_start : 10'd0;
    y_d           = de_d ? line_pos - c_v_start : 10'd0;
    r_out_d       = de_d ? r_in_q : 4'd0;
    g_out_d       = de_d ? g_in_q : 4'd0;
    b_out_d       = de_d ? b_in_q : 4'd0;
    frame_start_d = de_d && (h_pos == c_h_start) && (line_pos == c_v_start);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hs_q          <= 1'b0;
      hs_prev_q     <= 1'b0;
      vs_q          <= 1'b0;
      vs_prev_q     <= 1'b0;
      r_in_q        <= 4'd0;
      g_in_q        <= 4'd0;
      b_in_q        <= 4'd0;
      h_cnt_q       <= 10'd0;
      line_q        <= 10'd0;
      v_pend_q      <= 1'b0;
      state_q       <= ST_SEARCH;
      good_cnt_q    <= 4'd0;
      de_q          <= 1'b0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      r_out_q       <= 4'd0;
      g_out_q       <= 4'd0;
      b_out_q       <= 4'd0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      hs_q          <= hs_d;
      hs_prev_q     <= hs_q;
      vs_q          <= vs_d;
      vs_prev_q     <= vs_q;
      r_in_q        <= r_in_d;
      g_in_q        <= g_in_d;
      b_in_q        <= b_in_d;
      h_cnt_q       <= h_cnt_d;
      line_q        <= line_d;
      v_pend_q      <= v_pend_d;
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      r_out_q       <= r_out_d;
      g_out_q       <= g_out_d;
      b_out_q       <= b_out_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
    end
  end

  assign vga.DE          = de_q;
  assign vga.x_pixel     = x_q;
  assign vga.y_pixel     = y_q;
  assign vga.r_out       = r_out_q;
  assign vga.g_out       = g_out_q;
  assign vga.b_out       = b_out_q;
  assign vga.frame_start = frame_start_q;
  assign vga.locked      = locked_q;

`ifdef VGA_RX_ERR_CNT_EN
  logic       err_evt;
  logic [7:0] err_cnt_q, err_cnt_d;

  // Errors only count once a line-0 reference exists (not while searching).
  always_comb begin
    err_evt   = (state_q != ST_SEARCH) && (bad_line || (line0_edge && frame_len_bad));
    err_cnt_d = err_cnt_q;
    if (err_evt && err_cnt_q != 8'hff) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) err_cnt_q <= 8'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign vga.err_cnt = err_cnt_q;
`else
  assign vga.err_cnt = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_receiver.sv
// ============================================================================
// tb_vga_sync_receiver : scoreboard bench on a reduced video timing
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vga_sync_receiver;

  localparam int H_VIS = 16, H_FP = 2, H_SW = 4, H_BP = 3;
  localparam int V_VIS = 6,  V_FP = 1, V_SW = 1, V_BP = 2;
  localparam int LOCK  = 2;
  localparam int H_TOTAL = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SW + V_BP;
  localparam int H_START = H_SW + H_BP;
  localparam int V_START = V_SW + V_BP;

  typedef struct packed {
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       fs;
    logic       lk;
    logic [7:0] err;
  } out_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  vga_sync_receiver_if vga ();

  vga_sync_receiver #(
    .H_VISIBLE(H_VIS), .H_FRONT(H_FP), .H_SYNC(H_SW), .H_BACK(H_BP),
    .V_VISIBLE(V_VIS), .V_FRONT(V_FP), .V_SYNC(V_SW), .V_BACK(V_BP),
    .LOCK_FRAMES(LOCK)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .vga   (vga.slave)
  );

  always #5 clk = ~clk;

  out_t       exp_q[$];
  int         fid_q[$];
  int         n_checks = 0;
  int         n_pass = 0;
  int         de_cnt[0:15];
  int         fs_cnt[0:15];
  logic       exp_lock = 1'b0;
  logic [7:0] exp_err = 8'd0;
  int         good_run = 0;
  int         cur_frame = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // One clock: compare the output due now, then drive the next sample.
  task automatic tick(input logic hs, input logic vs, input logic [3:0] r, input logic [3:0] g,
                      input logic [3:0] b, input logic rst_n, input out_t e);
    out_t a, x;
    int   f;
    @(posedge clk);
    #1;
    if (exp_q.size() == 2) begin
      x = exp_q.pop_front();
      f = fid_q.pop_front();
      a.de = vga.DE;       a.x = vga.x_pixel;    a.y = vga.y_pixel;
      a.r  = vga.r_out;    a.g = vga.g_out;      a.b = vga.b_out;
      a.fs = vga.frame_start; a.lk = vga.locked; a.err = vga.err_cnt;
      check_val("out", 64'(a), 64'(x));
      if (a.de) de_cnt[f]++;
      if (a.fs) fs_cnt[f]++;
    end
    reset = rst_n;
    vga.h_sync = hs;
    vga.v_sync = vs;
    vga.r_port = r;
    vga.g_port = g;
    vga.b_port = b;
    if (!rst_n) begin
      foreach (exp_q[i]) exp_q[i] = '0;
      e = '0;
    end
    exp_q.push_back(e);
    fid_q.push_back(cur_frame);
  endtask

  task automatic pix(input int hp, input int ln, input logic vs, input logic rst_n);
    logic [9:0] xx, yy;
    logic [3:0] r, g, b;
    logic       act;
    out_t       e;
    xx  = 10'(hp - H_START);
    yy  = 10'(ln - V_START);
    r   = xx[3:0];
    g   = yy[3:0];
    b   = xx[3:0] ^ yy[3:0];
    act = (hp >= H_START) && (hp < H_START + H_VIS) && (ln >= V_START) && (ln < V_START + V_VIS);
    e     = '0;
    e.lk  = exp_lock;
    e.err = exp_err;
    if (act && exp_lock) begin
      e.de = 1'b1; e.x = xx; e.y = yy; e.r = r; e.g = g; e.b = b;
      e.fs = (xx == 10'd0) && (yy == 10'd0);
    end
    tick((hp < H_SW) ? 1'b0 : 1'b1, vs, r, g, b, rst_n, e);
  endtask

  task automatic disrupt();
    exp_lock = 1'b0;
    good_run = 0;
`ifdef VGA_RX_ERR_CNT_EN
    exp_err = exp_err + 8'd1;
`endif
  endtask

  // Frame with optional early v_sync fall, one short line, early stop, or reset pulse.
  task automatic frame(input bit early_v, input int short_ln, input int stop_ln,
                       input int rst_ln, input int rst_hp);
    logic vs;
    logic rn;
    int   len;
    cur_frame++;
    good_run++;
    for (int ln = 0; ln < V_TOTAL; ln++) begin
      if (stop_ln >= 0 && ln > stop_ln) break;
      len = (ln == short_ln) ? H_TOTAL - 1 : H_TOTAL;
      for (int hp = 0; hp < len; hp++) begin
        if (ln == 0 && hp == 0 && good_run > LOCK) exp_lock = 1'b1;
        if (short_ln >= 0 && ln == short_ln + 1 && hp == 0) disrupt();
        rn = 1'b1;
        if (ln == rst_ln && hp == rst_hp) begin
          rn = 1'b0; exp_lock = 1'b0; exp_err = 8'd0; good_run = 0;
        end
        vs = (ln < V_SW) ? 1'b0 : 1'b1;
        if (early_v && ln == V_TOTAL - 1 && hp >= 10) vs = 1'b0;
        pix(hp, ln, vs, rn);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vga.h_sync = 1'b1; vga.v_sync = 1'b1;
    vga.r_port = 4'd0; vga.g_port = 4'd0; vga.b_port = 4'd0;
    for (int i = 0; i < 3; i++) pix(900, 0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) pix(900, 0, 1'b1, 1'b1);
    // Frames 1-4: lock at start of frame 3; frame 4 preceded by an early v_sync fall.
    frame(0, -1, -1, -1, -1);
    frame(0, -1, -1, -1, -1);
    frame(1, -1, -1, -1, -1);
    frame(0, -1, -1, -1, -1);
    // Frame 5: line 4 one clock short while locked.
    frame(0, 4, -1, -1, -1);
    // Frames 6-8: re-lock, then h_sync stuck high mid-frame 8.
    frame(0, -1, -1, -1, -1);
    frame(0, -1, -1, -1, -1);
    frame(0, -1, 3, -1, -1);
    for (int i = 0; i < 2000; i++) begin
      if (H_TOTAL + i == 1023) disrupt();
      pix((H_TOTAL + i > 1023) ? 1023 : H_TOTAL + i, 3, 1'b1, 1'b1);
    end
    // Frames 9-11: re-lock after the stall; reset pulse mid-frame 11.
    frame(0, -1, -1, -1, -1);
    frame(0, -1, -1, -1, -1);
    frame(0, -1, -1, 5, 10);
    // Frames 12-14: full re-lock from reset.
    frame(0, -1, -1, -1, -1);
    frame(0, -1, -1, -1, -1);
    frame(0, -1, -1, -1, -1);
    for (int i = 0; i < 2; i++) pix(H_TOTAL + i, V_TOTAL - 1, 1'b1, 1'b1);

    check_val("de_count_f3",  64'(de_cnt[3]),  64'(H_VIS * V_VIS));
    check_val("de_count_f4",  64'(de_cnt[4]),  64'(H_VIS * V_VIS));
    check_val("de_count_f5",  64'(de_cnt[5]),  64'(2 * H_VIS));
    check_val("de_count_f8",  64'(de_cnt[8]),  64'(1 * H_VIS));
    check_val("de_count_f14", 64'(de_cnt[14]), 64'(H_VIS * V_VIS));
    check_val("de_count_f2",  64'(de_cnt[2]),  64'(0));
    check_val("fs_count_f3",  64'(fs_cnt[3]),  64'(1));
    check_val("fs_count_f4",  64'(fs_cnt[4]),  64'(1));
    check_val("fs_count_f14", 64'(fs_cnt[14]), 64'(1));
    check_val("fs_count_f13", 64'(fs_cnt[13]), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_sync_receiver.md
VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 SHALL have parameter H_VISIBLE, 640, active pixels per line.
REQ-002 SHALL have parameter H_FRONT/H_SYNC/H_BACK, 16/96/48, horizontal porch and sync widths in clocks.
REQ-003 SHALL have parameter V_VISIBLE, 480, active lines per frame.
REQ-004 SHALL have parameter V_FRONT/V_SYNC/V_BACK, 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameter LOCK_FRAMES, 2, consecutive good frames required to lock (1..15).
REQ-006 SHALL have ports clk in 1 pixel clock; reset in 1, synchronous and active-low (one clock; reset is synchronous and active-low).
REQ-007 SHALL have ports h_sync in 1 and v_sync in 1, both active-low.
REQ-008 SHALL have ports r_port/g_port/b_port in 4 each, sampled pixel colour.
REQ-009 SHALL have ports DE out 1 and x_pixel/y_pixel out 10 each, recovered active-area flag and coordinates.
REQ-010 SHALL have ports r_out/g_out/b_out out 4 each, captured colour aligned with DE/x/y.
REQ-011 SHALL have ports frame_start out 1, locked out 1, and err_cnt out 8.

Function
REQ-012 SHALL register all inputs once; sync edges detected on the registered copies; every output registered; pin-to-output latency exactly 2 clocks.
REQ-013 SHALL define an h-edge as registered h_sync 1->0; the input sample at that edge is h position 0; h_cnt increments per clock and saturates at 1023.
REQ-014 SHALL set line position 0 at the first h-edge coincident with or following a v_sync 1->0 edge; line counter increments per h-edge and saturates at 1023.
REQ-015 SHALL mark active when h_cnt in [H_SYNC+H_BACK, +H_VISIBLE) and line in [V_SYNC+V_BACK, +V_VISIBLE); x = h_cnt-144, y = line-35 at defaults.
REQ-016 SHALL drive DE=1 only when active AND locked; when DE=0, x_pixel, y_pixel, r_out, g_out, b_out SHALL be 0.
REQ-017 SHALL pulse frame_start for exactly 1 clock, coincident with the output x=0, y=0, DE=1.
REQ-018 SHALL mark a line bad if the h-edge spacing is not 800 (H_TOTAL) clocks or h_cnt saturates, and a frame bad if its line count is not 525 (V_TOTAL) or any line in it was bad.
REQ-019 SHALL implement FSM SEARCH->CHECK at the first line-0 edge; CHECK->LOCKED after LOCK_FRAMES consecutive good frames; CHECK->SEARCH on any bad line or frame.
REQ-020 SHALL transition LOCKED->SEARCH on any bad line or frame, with locked and DE falling on the next output cycle.
REQ-021 SHALL assert locked starting at the line-0 edge that completes the LOCK_FRAMES-th good frame.
REQ-022 SHALL treat simultaneous h-edge and v-edge as the start of line 0 at that edge.

Reset
REQ-023 SHALL, with reset=0 at a clock edge, enter SEARCH and clear all counters, input registers, and outputs (DE, x, y, rgb, frame_start, locked, err_cnt = 0) on that edge.
REQ-024 SHALL, on reset mid-frame, require a full re-lock (no retained state).

Configuration
REQ-025 SHALL, with VGA_RX_ERR_CNT_EN defined, increment err_cnt by 1 per bad line or frame event, saturating at 255 and cleared only by reset.
REQ-026 SHALL, without VGA_RX_ERR_CNT_EN, tie err_cnt to constant 0 and exclude its logic from synthesis.

Verification
REQ-027 SHALL cover: standard 640x480 source, 3 frames -> locked=1 at start of frame 3; pixel (0,0) emerges 2 clocks after input sample at h-edge+144 with frame_start=1.
REQ-028 SHALL cover: locked stream driving r_port=x[3:0] -> r_out equals x_pixel[3:0] for every DE=1 cycle; exactly 640x480 DE cycles per frame.
REQ-029 SHALL cover: one line shortened to 799 clocks while locked -> locked=0 and DE=0 from the next output cycle; err_cnt=1 when the macro is defined, else 0.
REQ-030 SHALL cover: h_sync held high 2000 clocks -> h_cnt saturates, locked=0, and re-lock occurs after 2 good frames.
REQ-031 SHALL cover: reset pulsed low mid-frame for 1 clock -> all outputs 0 the following cycle, FSM in SEARCH, and err_cnt=0.
REQ-032 SHALL cover: v_sync falling on the same clock as h_sync -> that line is line 0 and y=0 appears 35 lines later.
